// File: rtl/sram_banked_retention_wrapper.sv
// Banked single-port SRAM with req/gnt/rvalid handshake, byte-enabled writes,
// optional output register and per-bank idle-driven retention sleep with timed wake-up.
module sram_banked_retention_wrapper #(
    parameter  int N_BANKS        = 4,
    parameter  int WORDS_PER_BANK = 512,
    parameter  int DATA_W         = 32,
    parameter  int OUT_REG        = 0,
    parameter  int IDLE_CYCLES    = 64,
    parameter  int WAKE_CYCLES    = 4,
    localparam int ADDR_W         = $clog2(N_BANKS * WORDS_PER_BANK),
    localparam int BANK_W         = $clog2(N_BANKS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  scan_en_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   be_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [N_BANKS-1:0]    bank_sleep_o
);

    localparam int ROW_W   = $clog2(WORDS_PER_BANK);
    localparam int SEL_W   = (BANK_W > 0) ? BANK_W : 1;
    localparam int NBYTES  = DATA_W / 8;
    localparam int MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } state_e;

    logic [SEL_W-1:0]                bank_sel;
    logic [ROW_W-1:0]                row;
    logic [N_BANKS-1:0]              bank_active;
    logic [N_BANKS-1:0][DATA_W-1:0]  bank_rdata;
    logic                            gnt;

    if (BANK_W > 0) begin : g_sel
        assign bank_sel = addr_i[ADDR_W-1 -: BANK_W];
    end else begin : g_sel_one
        assign bank_sel = 1'b0;
    end

    assign row = addr_i[ROW_W-1:0];

    // Reset gates the grant so nothing commits while the FSMs are being cleared.
    assign gnt   = rst_ni & req_i & ~scan_en_i & bank_active[bank_sel];
    assign gnt_o = gnt;

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        state_e             state_q, state_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic               hit, acc;
        logic [DATA_W-1:0]  mem_q [WORDS_PER_BANK];

        assign hit = req_i & (bank_sel == SEL_W'(b));
        assign acc = gnt & hit;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                state_q <= ST_ACTIVE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (!scan_en_i) begin
                case (state_q)
                    ST_ACTIVE: begin
                        if (acc) begin
                            cnt_d = '0;
                        end else if (IDLE_CYCLES != 0) begin
                            if (cnt_q == IDLE_LAST) begin
                                state_d = ST_SLEEP;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_SLEEP: begin
                        if (hit) begin
                            state_d = ST_WAKE;
                            cnt_d   = WAKE_LOAD;
                        end
                    end
                    ST_WAKE: begin
                        if (cnt_q == '0) begin
                            state_d = ST_ACTIVE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        // Storage is deliberately not reset: contents survive both reset and sleep.
        always_ff @(posedge clk_i) begin
            if (acc && we_i) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (be_i[i]) mem_q[row][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end

        assign bank_rdata[b]   = mem_q[row];
        assign bank_active[b]  = (state_q == ST_ACTIVE);
        assign bank_sleep_o[b] = (state_q != ST_ACTIVE);
    end

    logic              s1_vld_q;
    logic [DATA_W-1:0] s1_data_q;

    // s1_data_q only loads on reads, so it always holds the most recent read word.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
        end else begin
            s1_vld_q <= gnt;
            if (gnt && !we_i) s1_data_q <= bank_rdata[bank_sel];
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic              s2_vld_q;
        logic [DATA_W-1:0] s2_data_q;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                s2_vld_q  <= 1'b0;
                s2_data_q <= '0;
            end else begin
                s2_vld_q  <= s1_vld_q;
                s2_data_q <= s1_data_q;
            end
        end

        assign rvalid_o = s2_vld_q;
        assign rdata_o  = s2_data_q;
    end else begin : g_noreg
        assign rvalid_o = s1_vld_q;
        assign rdata_o  = s1_data_q;
    end

endmodule
